// File: rtl/arrow_key_capture.sv
// ---------------------------------------------------------------------------
// arrow_key_capture
//
// Purpose:
//   Takes N raw board keys, synchronises and debounces each one, reports the
//   direction code of the single held key as a level, and queues every fresh
//   single-key press as a direction event in a small first-word-fall-through
//   FIFO. The game FSM consumes events through a valid/ready handshake, so a
//   press is neither lost nor counted twice.
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   keys_in     in   raw key inputs, [0]=left [1]=down [2]=up [3]=right
//   enable      in   1 = press events are queued
//   flush       in   empty the FIFO and clear overflow
//   dir_level   out  code of the single held key, all-ones otherwise
//   dir_data    out  head-of-FIFO code, all-ones when empty
//   dir_valid   out  FIFO not empty
//   dir_ready   in   consumer accepts the head entry
//   fifo_count  out  number of queued events
//   overflow    out  sticky: an event was dropped while the FIFO was full
// ---------------------------------------------------------------------------
module arrow_key_capture #(
   parameter int N_KEYS          = 4,
   parameter int CODE_W          = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic                              clock,
   input  logic                              resetn,
   input  logic [N_KEYS-1:0]                 keys_in,
   input  logic                              enable,
   input  logic                              flush,
   output logic [CODE_W-1:0]                 dir_level,
   output logic [CODE_W-1:0]                 dir_data,
   output logic                              dir_valid,
   input  logic                              dir_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CODE_W-1:0] NOTHING  = {CODE_W{1'b1}};
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

   logic [N_KEYS-1:0] keys_norm;
   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] sync2;
   logic [N_KEYS-1:0] stable;
   logic [N_KEYS-1:0] stable_prev;
   logic [DB_W-1:0]   db_cnt [N_KEYS];

   logic              stable_onehot;
   logic [CODE_W-1:0] stable_code;
   logic              press_event;

   logic [CODE_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              pop;
   logic              push_req;
   logic              push_ok;

   // Everything downstream works in "1 = pressed" terms, so active-low boards
   // are inverted right at the pins.
   assign keys_norm = (ACTIVE_LOW != 0) ? ~keys_in : keys_in;

   // A one-hot test that avoids a priority chain: clearing the lowest set bit
   // of a one-hot vector leaves nothing behind.
   assign stable_onehot = (stable != '0) &&
                          ((stable & (stable - N_KEYS'(1))) == '0);

   // Index of the set bit in the debounced vector. Only meaningful while the
   // vector is one-hot, which is the only time it is consumed.
   always_comb begin
      stable_code = NOTHING;
      for (int i = 0; i < N_KEYS; i++) begin
         if (stable[i]) begin
            stable_code = CODE_W'(i);
         end
      end
   end

   // A press only counts when the keyboard was fully idle on the previous
   // cycle, so chords and keys left over from a chord never generate events.
   assign press_event = stable_onehot && (stable_prev == '0);

   // Synchroniser, per-key debounce and the registered direction level.
   // A key's stable bit only flips after the synchronised level has disagreed
   // with it for DEBOUNCE_CYCLES edges in a row; any agreeing edge restarts
   // the count, which is what swallows contact bounce.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync1       <= '0;
         sync2       <= '0;
         stable      <= '0;
         stable_prev <= '0;
         dir_level   <= NOTHING;
         for (int i = 0; i < N_KEYS; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1       <= keys_norm;
         sync2       <= sync1;
         stable_prev <= stable;
         dir_level   <= stable_onehot ? stable_code : NOTHING;
         for (int i = 0; i < N_KEYS; i++) begin
            if (sync2[i] != stable[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  stable[i] <= ~stable[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // FIFO handshake decode. A full queue still takes a push when the head is
   // leaving on the same edge; flush wins over both push and pop.
   assign full     = (count == CNT_FULL);
   assign pop      = dir_valid & dir_ready;
   assign push_req = press_event & enable & ~flush;
   assign push_ok  = push_req & (~full | pop);

   // Event storage. Contents need no reset because dir_data is forced to
   // NOTHING whenever the queue is empty.
   always_ff @(posedge clock) begin
      if (resetn && push_ok) begin
         mem[wr_ptr] <= stable_code;
      end
   end

   // Pointers, occupancy and the sticky overflow flag. Pointers wrap
   // naturally because the depth is a power of two.
   always_ff @(posedge clock) begin
      if (!resetn || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_ok && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push_ok) begin
            count <= count - CNT_W'(1);
         end
         if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign dir_valid  = (count != '0);
   assign dir_data   = dir_valid ? mem[rd_ptr] : NOTHING;
   assign fifo_count = count;

endmodule

// File: doc/arrow_key_capture.md
Name: arrow_key_capture

Overview:
Parametrised successor to the arrow selector. Synchronises and debounces N key inputs and produces a level direction code while exactly one key is held. Each new single-key press is queued as a direction event in a small first-word-fall-through FIFO with a valid/ready handshake. Sits between the board keys and the Simon Says game FSM, so presses are never lost or double-counted.

Parameters:
N_KEYS, 4, number of key inputs; must satisfy N_KEYS <= 2^CODE_W - 1.
CODE_W, 3, direction code width. Key i encodes as i. All-ones is NOTHING.
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a change (>=1); use ~500000 for board builds.
FIFO_DEPTH, 4, event queue depth; power of 2, >=2.
ACTIVE_LOW, 0, 1 = keys_in pressed level is 0; inputs are inverted on entry.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
keys_in  in  N_KEYS  raw key inputs. Default map: [0]=left, [1]=down, [2]=up, [3]=right, giving 000/001/010/011.
enable  in  1  1 = press events are queued
flush  in  1  empty FIFO, clear overflow
dir_level  out  CODE_W  code of the single held key, else all-ones
dir_data  out  CODE_W  head-of-FIFO code; all-ones when empty
dir_valid  out  1  FIFO not empty
dir_ready  in  1  consumer accepts head
fifo_count  out  clog2(FIFO_DEPTH+1)  queued events
overflow  out  1  sticky: an event was dropped while the FIFO was full

Behaviour:
- Input path: optional inversion, then a 2-flop synchroniser per key. Sync flops reset to the released level.
- Debounce, per key:
  - The counter increments on each edge where the synced value differs from the stable value.
  - The counter clears on any edge where they are equal.
  - On the edge where the count would reach DEBOUNCE_CYCLES, the stable bit flips and the counter clears.
  - Counter width: clog2(DEBOUNCE_CYCLES+1).
- stable_prev register holds the previous stable vector.
- Press event = stable is one-hot AND stable_prev is all-zero. Event code = index of the set bit.
- Multi-key chords produce no event. A later single key also produces no event until all keys have been released first.
- A release produces no event.
- Latency: let edge k be the first to sample a new raw level into sync1.
  - The stable bit flips at edge k+1+D (D = DEBOUNCE_CYCLES).
  - The event is written at edge k+2+D.
  - dir_valid is high after edge k+2+D, if the FIFO was empty.
- dir_level: registered. Equals the code of the stable vector when it is one-hot, else all-ones. Updates at edge k+2+D. Independent of enable and flush.
- FIFO:
  - Push = event & enable & ~flush.
  - Pop = dir_valid & dir_ready.
  - dir_data is the head combinationally from storage (FWFT).
  - Push and pop in the same edge: both occur, count unchanged.
  - When full, push with pop is accepted. Push without pop is dropped and overflow is set.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- flush: at the edge, count goes to 0, pointers go to 0, overflow clears. Flush beats a simultaneous push or pop. Debounce state is untouched.
- enable=0: debounce and dir_level still run; events are discarded without setting overflow.
- Reset (resetn=0 at an edge) clears everything, overriding all other inputs, including mid-debounce or a non-empty FIFO:
  - sync, stable and stable_prev go to released; counters go to 0.
  - FIFO empties; overflow=0.
  - dir_level and dir_data go to all-ones; dir_valid=0; fifo_count=0.
  - A key held through reset yields one press event after debounce once released/pressed semantics apply, i.e. it appears as a fresh press D+3 edges after reset release.

Test Plan:
- Defaults (D=4). Press keys_in=4'b0100 from reset-idle, first sampled at edge k -> dir_valid=1 and dir_data=3'b010 after edge k+6; dir_level=3'b010 after edge k+6; dir_ready=1 for one cycle pops it, fifo_count=0.
- Bounce: a 3-cycle glitch on keys_in[1], then release -> no event, dir_level stays 3'b111, counter returns to 0.
- Chord and release ordering: press [0]; add [3] while held; release [0]; keep [3] held -> exactly one event (3'b000). dir_level goes 000 -> 111 -> 011. No event for [3] until all keys are released and [3] is pressed again.
- Full FIFO with dir_ready=0: 5 separate presses (left, down, up, right, left) -> fifo_count=4, overflow=1, queue holds 000,001,010,011. A 5th press arriving with a simultaneous pop is accepted, count stays 4.
- flush coincident with an event edge, then reset mid-debounce -> FIFO empty, overflow=0, event dropped. After resetn is asserted, all outputs are at reset values: dir_data=3'b111, dir_valid=0.
- ACTIVE_LOW=1, enable=0: keys_in=4'b1110 held -> dir_level=3'b000 and no event queued. Raise enable while still held -> still no event.
